ucsbece154b_fetch_queue: RTL and testbench



---
 rtl/ucsbece154b_fetch_queue.sv | 108 ++++++++++
 tb/tb_ucsbece154b_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_fetch_queue.sv
// Fetch PC generator plus DEPTH-entry fetch-to-decode queue; head visible the cycle after enqueue, fetch halts only when full.
// Optional JAL pre-decode/prediction under UCSBECE154B_FQ_JALPRED_EN; execute redirect flushes everything.
module ucsbece154b_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_START = 32'h00010000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            PCF_o,
  input  logic [ILEN-1:0]            InstrF_i,
  input  logic                       ImemReadyF_i,
  input  logic                       RedirectE_i,
  input  logic [XLEN-1:0]            PCTargetE_i,
  input  logic                       StallD_i,
  output logic [ILEN-1:0]            InstrD_o,
  output logic [XLEN-1:0]            PCD_o,
  output logic [XLEN-1:0]            PCPlus4D_o,
  output logic                       PredTakenD_o,
  output logic                       ValidD_o,
  output logic [$clog2(DEPTH+1)-1:0] CountF_o,
  output logic                       FullF_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            pred;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pcF, pcPlus4F, nextPcF;
  logic            predF, enq, deq;
  entry_t          head;

  assign pcPlus4F = pcF + XLEN'(4);

`ifdef UCSBECE154B_FQ_JALPRED_EN
  logic            isJalF;
  logic [XLEN-1:0] jImmF;
  assign isJalF  = (InstrF_i[6:0] == 7'b1101111);
  assign jImmF   = {{(XLEN-21){InstrF_i[31]}}, InstrF_i[31], InstrF_i[19:12],
                    InstrF_i[20], InstrF_i[30:21], 1'b0};
  assign predF   = isJalF;
  assign nextPcF = isJalF ? (pcF + jImmF) : pcPlus4F;
`else
  assign predF   = 1'b0;
  assign nextPcF = pcPlus4F;
`endif

  assign ValidD_o = (count != '0);
  assign FullF_o  = (count == CW'(DEPTH));
  assign CountF_o = count;
  assign PCF_o    = pcF;

  // A full queue may still accept when the head leaves in the same cycle.
  assign enq = ImemReadyF_i & ~RedirectE_i & (~FullF_o | deq);
  assign deq = ValidD_o & ~StallD_i & ~RedirectE_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF   <= PC_START;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (RedirectE_i) begin
      pcF   <= PCTargetE_i;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        pcF   <= nextPcF;
        wrPtr <= wrPtr + PW'(1);
      end
      if (deq) rdPtr <= rdPtr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity comes from the count alone.
  always_ff @(posedge clk) begin
    if (enq && !reset) mem[wrPtr] <= '{instr: InstrF_i, pc: pcF, pcPlus4: pcPlus4F, pred: predF};
  end

  // Empty head presents an all-zero bubble to decode.
  always_comb begin
    head = '0;
    if (ValidD_o) head = mem[rdPtr];
  end

  assign InstrD_o     = head.instr;
  assign PCD_o        = head.pc;
  assign PCPlus4D_o   = head.pcPlus4;
  assign PredTakenD_o = head.pred;

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Scoreboard bench for ucsbece154b_fetch_queue (DEPTH=4, PC_START=0x10000).
module tb_ucsbece154b_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] PC_START = 32'h00010000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF_o, InstrF_i, PCTargetE_i, InstrD_o, PCD_o, PCPlus4D_o;
  logic        ImemReadyF_i, RedirectE_i, StallD_i, PredTakenD_o, ValidD_o, FullF_o;
  logic [2:0]  CountF_o;

  ucsbece154b_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .PC_START(PC_START)) dut (
    .clk(clk), .reset(reset), .PCF_o(PCF_o), .InstrF_i(InstrF_i),
    .ImemReadyF_i(ImemReadyF_i), .RedirectE_i(RedirectE_i), .PCTargetE_i(PCTargetE_i),
    .StallD_i(StallD_i), .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
    .PredTakenD_o(PredTakenD_o), .ValidD_o(ValidD_o), .CountF_o(CountF_o), .FullF_o(FullF_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] modelPc;
  int          vectors = 0;
  int          miscompares = 0;

  // One cycle: drive at the falling edge, retire the scoreboard head if decode takes it, update the model.
  task automatic tick(input logic rdy, input logic stall, input logic redir,
                      input logic [31:0] target, input logic useInstr, input logic [31:0] instr);
    logic        enq, deq, pred;
    logic [31:0] ins, nxt;
    exp_t        e;
    ins = useInstr ? instr : {modelPc[24:0], 7'b0010011};
    ImemReadyF_i = rdy; StallD_i = stall; RedirectE_i = redir;
    PCTargetE_i = target; InstrF_i = ins;
    deq = (sbq.size() > 0) && !stall && !redir;
    enq = rdy && !redir && ((sbq.size() < DEPTH) || deq);
    pred = 1'b0;
    nxt = modelPc + 32'd4;
`ifdef UCSBECE154B_FQ_JALPRED_EN
    if (ins[6:0] == 7'h6F) begin
      pred = 1'b1;
      nxt = modelPc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    end
`endif
    if (deq) begin
      e = sbq[0];
      vectors++;
      if ({InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o} !== e) begin
        miscompares++;
        $display("FAIL deq_head: got instr=%h pc=%h pc4=%h pred=%b, need instr=%h pc=%h pc4=%h pred=%b",
                 InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o, e.instr, e.pc, e.pc4, e.pred);
      end
    end
    @(posedge clk);
    if (redir) begin
      sbq.delete();
      modelPc = target;
    end else begin
      if (deq) void'(sbq.pop_front());
      if (enq) begin
        sbq.push_back('{instr: ins, pc: modelPc, pc4: modelPc + 32'd4, pred: pred});
        modelPc = nxt;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; ImemReadyF_i = 1'b0; StallD_i = 1'b0; RedirectE_i = 1'b0;
    PCTargetE_i = '0; InstrF_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    modelPc = PC_START;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({PCF_o, CountF_o, ValidD_o, FullF_o} !== {PC_START, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got pc=%h cnt=%0d v=%b f=%b, need pc=%h cnt=0 v=0 f=0",
               PCF_o, CountF_o, ValidD_o, FullF_o, PC_START);
    end
    vectors++;
    if ({InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_bubble: got instr=%h pc=%h pc4=%h pred=%b, need all zero",
               InstrD_o, PCD_o, PCPlus4D_o, PredTakenD_o);
    end
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      vectors++;
      if (PCF_o !== 32'h10004 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_pcf[%0d]: got %h need %h", i, PCF_o, 32'h10004 + 32'(4 * i));
      end
      vectors++;
      if ({ValidD_o, PCD_o, PCPlus4D_o} !== {1'b1, 32'h10000 + 32'(4 * i), 32'h10004 + 32'(4 * i)}) begin
        miscompares++;
        $display("FAIL stream_head[%0d]: got v=%b pc=%h pc4=%h need v=1 pc=%h", i, ValidD_o, PCD_o,
                 PCPlus4D_o, 32'h10000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_full();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      vectors++;
      if ({CountF_o, FullF_o} !== {3'((i < 3) ? i + 1 : 4), (i >= 3)}) begin
        miscompares++;
        $display("FAIL stall_count[%0d]: got cnt=%0d full=%b need cnt=%0d", i, CountF_o, FullF_o,
                 (i < 3) ? i + 1 : 4);
      end
    end
    vectors++;
    if ({PCF_o, PCD_o} !== {32'h10010, 32'h10000}) begin
      miscompares++;
      $display("FAIL stall_hold: got pcf=%h head=%h need pcf=00010010 head=00010000", PCF_o, PCD_o);
    end
  endtask

  task automatic test_full_release();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      vectors++;
      if ({CountF_o, PCD_o, PCF_o} !== {3'd4, 32'h10004 + 32'(4 * i), 32'h10014 + 32'(4 * i)}) begin
        miscompares++;
        $display("FAIL full_release[%0d]: got cnt=%0d head=%h pcf=%h need cnt=4 head=%h pcf=%h", i,
                 CountF_o, PCD_o, PCF_o, 32'h10004 + 32'(4 * i), 32'h10014 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) tick(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b1, 32'h20040, 1'b0, '0);
    vectors++;
    if ({CountF_o, ValidD_o, InstrD_o, PCF_o} !== {3'd0, 1'b0, 32'h0, 32'h20040}) begin
      miscompares++;
      $display("FAIL redirect_flush: got cnt=%0d v=%b instr=%h pcf=%h need cnt=0 v=0 instr=0 pcf=00020040",
               CountF_o, ValidD_o, InstrD_o, PCF_o);
    end
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    vectors++;
    if ({CountF_o, PCD_o, PCPlus4D_o} !== {3'd1, 32'h20040, 32'h20044}) begin
      miscompares++;
      $display("FAIL redirect_first: got cnt=%0d pc=%h pc4=%h need cnt=1 pc=00020040 pc4=00020044",
               CountF_o, PCD_o, PCPlus4D_o);
    end
  endtask

  task automatic test_imem_wait();
    logic rdySeq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] pcExp [4] = '{32'h20048, 32'h20048, 32'h20048, 32'h2004C};
    logic [2:0] cntExp [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 4; i++) begin
      tick(rdySeq[i], 1'b1, 1'b0, '0, 1'b0, '0);
      vectors++;
      if ({PCF_o, CountF_o} !== {pcExp[i], cntExp[i]}) begin
        miscompares++;
        $display("FAIL imem_wait[%0d]: got pcf=%h cnt=%0d need pcf=%h cnt=%0d", i, PCF_o, CountF_o,
                 pcExp[i], cntExp[i]);
      end
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    vectors++;
    if ({CountF_o, ValidD_o, PCD_o} !== {3'd0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL drain_empty: got cnt=%0d v=%b pc=%h need 0/0/0", CountF_o, ValidD_o, PCD_o);
    end
  endtask

  task automatic test_jal();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0100006F);
`ifdef UCSBECE154B_FQ_JALPRED_EN
    vectors++;
    if ({PCF_o, PredTakenD_o} !== {32'h10010, 1'b1}) begin
      miscompares++;
      $display("FAIL jal_pred: got pcf=%h pred=%b need pcf=00010010 pred=1", PCF_o, PredTakenD_o);
    end
`else
    vectors++;
    if ({PCF_o, PredTakenD_o} !== {32'h10004, 1'b0}) begin
      miscompares++;
      $display("FAIL jal_nopred: got pcf=%h pred=%b need pcf=00010004 pred=0", PCF_o, PredTakenD_o);
    end
`endif
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic rdy, stall, redir;
    for (int i = 0; i < 60; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 2) == 0);
      redir = ($urandom_range(0, 15) == 0);
      tick(rdy, stall, redir, {$urandom_range(0, 32'hFFFF), 2'b00}, 1'b0, '0);
      vectors++;
      if ({PCF_o, CountF_o, FullF_o, ValidD_o} !==
          {modelPc, 3'(sbq.size()), (sbq.size() == DEPTH), (sbq.size() != 0)}) begin
        miscompares++;
        $display("FAIL random[%0d]: got pcf=%h cnt=%0d f=%b v=%b need pcf=%h cnt=%0d", i, PCF_o,
                 CountF_o, FullF_o, ValidD_o, modelPc, sbq.size());
      end
    end
    repeat (2) tick(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    do_reset();
    vectors++;
    if ({PCF_o, CountF_o, ValidD_o} !== {PC_START, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrun_reset: got pcf=%h cnt=%0d v=%b need pcf=%h cnt=0 v=0", PCF_o, CountF_o,
               ValidD_o, PC_START);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch_stream();
    test_stall_full();
    test_full_release();
    test_redirect();
    test_imem_wait();
    test_jal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
